// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: RV32I opcodes, fetch FSM states
// and the instruction buffer entry type.
package fd_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP,
      OP_MISC_MEM, OP_SYSTEM: is_rv32i_opcode = 1'b1;
      default:                is_rv32i_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bus bundle between fetch_decode, instruction memory and the datapath.
// Optional ILLEGAL_TRAP_EN adds the illegal-instruction flag.
interface fetch_decode_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        reg_write;
  logic [3:0]  mem_write_enable;
  logic        store_enable;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_pc, rd, rs1, rs2, opcode, func3, func7, imm,
    output reg_write, mem_write_enable, store_enable,
`ifdef ILLEGAL_TRAP_EN
    output illegal,
`endif
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_pc, rd, rs1, rs2, opcode, func3, func7, imm,
    input  reg_write, mem_write_enable, store_enable,
`ifdef ILLEGAL_TRAP_EN
    input  illegal,
`endif
    output dec_ready
  );
endinterface

// File: rtl/fetch_decode_instr_decoder.sv
// Combinational RV32I field/immediate/store-control decoder.
// With ILLEGAL_TRAP_EN defined it also flags illegal instructions and suppresses side effects.
module instr_decoder
  import fd_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  func3_o,
  output logic [6:0]  func7_o,
  output logic [31:0] imm_o,
  output logic        reg_write_o,
  output logic [3:0]  mem_write_enable_o,
`ifdef ILLEGAL_TRAP_EN
  output logic        illegal_o,
`endif
  output logic        store_enable_o
);

  logic [6:0] opc;
  logic       writes_rd;
  logic       is_store;
  logic [3:0] store_mask;

  assign opc      = instr_i[6:0];
  assign rd_o     = instr_i[11:7];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign opcode_o = opc;
  assign func3_o  = instr_i[14:12];
  assign func7_o  = instr_i[31:25];
  assign is_store = (opc == OP_STORE);

  always_comb begin
    imm_o = '0;
    case (opc)
      OP_IMM, OP_LOAD, OP_JALR: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OP_STORE:  imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OP_BRANCH: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_o = {instr_i[31:12], 12'h000};
      OP_JAL: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

  always_comb begin
    writes_rd = 1'b0;
    case (opc)
      OP_OP, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

  always_comb begin
    store_mask = 4'b0000;
    if (is_store) begin
      case (instr_i[14:12])
        3'b000:  store_mask = 4'b0001;
        3'b001:  store_mask = 4'b0011;
        3'b010:  store_mask = 4'b1111;
        default: store_mask = 4'b0000;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_comb begin
    illegal_o = !is_rv32i_opcode(opc) ||
                ((opc == OP_OP) && (instr_i[31:25] != 7'b0000000) &&
                 (instr_i[31:25] != 7'b0100000));
  end

  assign reg_write_o        = writes_rd && (instr_i[11:7] != 5'd0) && !illegal_o;
  assign store_enable_o     = is_store && !illegal_o;
  assign mem_write_enable_o = illegal_o ? 4'b0000 : store_mask;
`else
  assign reg_write_o        = writes_rd && (instr_i[11:7] != 5'd0);
  assign store_enable_o     = is_store;
  assign mem_write_enable_o = store_mask;
`endif

endmodule

// File: rtl/fetch_decode.sv
// Front end: PC, single-outstanding instruction fetch, DEPTH-entry buffer, head decode.
// Define ILLEGAL_TRAP_EN to add the illegal-instruction output.
module fetch_decode
  import fd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic            clock,
  input logic            reset,
  fetch_decode_if.master bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic          discard_q, discard_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];

  logic [PtrW-1:0] count;
  logic [PtrW-1:0] count_after;
  logic          empty, full, pop, push;
  fetch_entry_t  head;
  logic [31:0]   dec_instr;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
  assign pop   = !empty && bus.dec_ready;
  // Occupancy once the response in WAIT is pushed, net of any same-cycle pop.
  assign count_after = count + PtrOne - (pop ? PtrOne : '0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;
    push      = 1'b0;

    if (pop) rptr_d = rptr_q + PtrOne;

    case (state_q)
      StIdle: if (!full) state_d = StReq;
      StReq: begin
        if (bus.imem_gnt) begin
          pc_d    = pc_q + 32'd4;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            push    = 1'b1;
            state_d = (count_after < DepthP) ? StReq : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything above: flush, retarget, and poison any in-flight fetch.
    if (bus.redirect_valid) begin
      push   = 1'b0;
      rptr_d = wptr_q;
      pc_d   = {bus.redirect_pc[31:2], 2'b00};
      case (state_q)
        StWait: begin
          if (bus.imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            discard_d = 1'b1;
            state_d   = StWait;
          end
        end
        StReq: begin
          if (bus.imem_gnt) begin
            discard_d = 1'b1;
            state_d   = StWait;
          end else begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end

    if (push) begin
      mem_d[wptr_q[IdxW-1:0]] = '{pc: pc_q - 32'd4, instr: bus.imem_rdata};
      wptr_d = wptr_q + PtrOne;
    end

    req_d = (state_d == StReq);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;

  assign head          = mem_q[rptr_q[IdxW-1:0]];
  // Feeding zero when empty keeps every decoded field at zero without per-field gating.
  assign dec_instr     = empty ? 32'h0 : head.instr;
  assign bus.dec_valid = !empty;
  assign bus.dec_pc    = empty ? 32'h0 : head.pc;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_raw;
  assign bus.illegal = illegal_raw && !empty;
`endif

  instr_decoder u_instr_decoder (
    .instr_i            (dec_instr),
    .rd_o               (bus.rd),
    .rs1_o              (bus.rs1),
    .rs2_o              (bus.rs2),
    .opcode_o           (bus.opcode),
    .func3_o            (bus.func3),
    .func7_o            (bus.func7),
    .imm_o              (bus.imm),
    .reg_write_o        (bus.reg_write),
    .mem_write_enable_o (bus.mem_write_enable),
`ifdef ILLEGAL_TRAP_EN
    .illegal_o          (illegal_raw),
`endif
    .store_enable_o     (bus.store_enable)
  );

endmodule
